bbbb_initiator: RTL
===================

BBBB_INITIATOR -- requirements
Module: bbbb_initiator

Interface
REQ-001 SHALL have parameter RETRY_MAX, default 3, meaning the maximum number of reissues after a RETRY response.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum consecutive WAIT cycles per attempt (range 1..255).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL provide these ports (name, direction, width, meaning):
- clk  in  1  clock, all state updates on its rising edge
- rst  in  1  synchronous active-high reset
- in_cmd_valid  in  1  command offered
- out_cmd_ready  out  1  command accepted when valid and ready are both high
- in_cmd_write  in  1  1 = write, 0 = read
- in_cmd_addr  in  32  transfer address
- in_cmd_wdata  in  32  write data
- out_rsp_valid  out  1  response held until accepted
- in_rsp_accept  in  1  response consumed
- out_rsp_rdata  out  32  read data (0 for writes and failures)
- out_rsp_err  out  2  00 OK, 01 ERROR, 10 TIMEOUT, 11 RETRY_EXHAUSTED
- out_bbbb_sel  out  1  bus select
- out_bbbb_addr  out  32  bus address
- out_bbbb_write  out  1  bus direction
- out_bbbb_trans  out  2  00 IDLE, 10 NONSEQ
- out_bbbb_wdata  out  32  bus write data
- in_bbbb_rdata  in  32  responder read data
- in_bbbb_resp  in  2  00 OKAY, 01 ERROR, 10 WAIT, 11 RETRY
- out_irq  out  1  high while out_rsp_valid=1 and out_rsp_err!=00

Function
REQ-005 SHALL implement states IDLE, BUSY, GAP and RESP, and SHALL drive all bus and response outputs directly from registers.
REQ-006 SHALL drive out_cmd_ready=1 only in IDLE; command handshake at edge T SHALL latch write/addr/wdata and enter BUSY, with out_bbbb_sel=1 and trans=10 from T+1.
REQ-007 SHALL hold out_bbbb_addr, out_bbbb_write and out_bbbb_wdata stable while out_bbbb_sel=1.
REQ-008 SHALL sample in_bbbb_resp on every edge in BUSY.
REQ-009 On WAIT in BUSY, SHALL stay in BUSY and increment the wait counter.
REQ-010 On OKAY in BUSY, SHALL capture in_bbbb_rdata (reads only), set err=00, drop sel and trans to 0, and enter RESP; a zero-wait read SHALL give out_rsp_valid at T+2.
REQ-011 On ERROR in BUSY, SHALL set err=01, set rdata=0, drop sel, and enter RESP.
REQ-012 On RETRY in BUSY with retry count < RETRY_MAX, SHALL increment the retry count, drop sel for exactly one cycle (GAP), and reissue the identical transfer; the wait counter SHALL clear per attempt.
REQ-013 On RETRY in BUSY with retry count = RETRY_MAX, SHALL set err=11, drop sel, and enter RESP.
REQ-014 When the wait counter reaches TIMEOUT with resp still WAIT, SHALL set err=10, drop sel, and enter RESP; responses that arrive after sel drops SHALL be ignored.
REQ-015 In RESP, SHALL hold out_rsp_valid=1 with stable data until in_rsp_accept=1, then return to IDLE, with out_cmd_ready=1 on the next cycle; no command SHALL be accepted in the same cycle as the response accept.
REQ-016 SHALL ignore in_cmd_valid outside IDLE and in_rsp_accept outside RESP.
REQ-017 Retry and wait counters SHALL saturate and never wrap; retry count SHALL clear on each new command.

Reset
REQ-018 rst=1 SHALL force at the next edge: state IDLE, out_cmd_ready=1, sel=0, trans=00, addr/wdata/write=0, out_rsp_valid=0, rdata=0, err=00, out_irq=0, counters=0.
REQ-019 rst mid-transfer or mid-response SHALL abandon the transfer without emitting a response; rst SHALL take priority over all other events.

Structure
REQ-020 Package bbbb_pkg SHALL hold the trans encodings, resp encodings, err codes and the state enum, shared with the bbbb responder.
REQ-021 The wait/timeout counter SHALL be sub-module bbbb_wait_timer (inputs clear and count, output expired); everything else SHALL stay flat.

Verification
REQ-022 Read addr=0x10 with responder OKAY and rdata=0xDEADBEEF at first sample -> sel high for exactly 1 cycle; rsp_valid at T+2 with rdata=0xDEADBEEF and err=00.
REQ-023 Write addr=0x04, wdata=0x5A5A5A5A with 3 WAITs then OKAY -> sel high for 4 cycles with addr/wdata stable; err=00, rdata=0.
REQ-024 Responder always RETRY with RETRY_MAX=3 -> 4 attempts each separated by one sel=0 cycle; err=11 and out_irq=1 until accept.
REQ-025 Responder always WAIT with TIMEOUT=8 -> sel drops after 8 WAIT samples; err=10; a late OKAY is ignored.
REQ-026 rst pulsed during BUSY, then in_rsp_accept held low for 5 cycles in RESP of a following ERROR transfer -> no response after reset; err=01 response held stable for 5 cycles; ready=1 the cycle after accept.

Source files
------------

// File: rtl/bbbb_pkg.sv
// Shared encodings for the BBBB bus: transfer types, responder responses,
// initiator error codes and the initiator state enum.
package bbbb_pkg;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [1:0] RESP_WAIT  = 2'b10;
    localparam logic [1:0] RESP_RETRY = 2'b11;

    localparam logic [1:0] ERR_OK              = 2'b00;
    localparam logic [1:0] ERR_ERROR           = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT         = 2'b10;
    localparam logic [1:0] ERR_RETRY_EXHAUSTED = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2,
        ST_RESP = 2'd3
    } bbbb_state_e;

    function automatic logic is_fail(input logic [1:0] err);
        return err != ERR_OK;
    endfunction

endpackage

// File: rtl/bbbb_wait_timer.sv
// Per-attempt WAIT counter; expired flags that the WAIT being sampled now
// is the TIMEOUT-th consecutive one of the current attempt.
module bbbb_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);

    logic [7:0] cnt;

    // Saturates at TIMEOUT so a stuck count can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= 8'd0;
        end else if (count && (cnt != 8'(TIMEOUT))) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = (cnt >= 8'(TIMEOUT - 1));

endmodule

// File: rtl/bbbb_initiator.sv
// BBBB bus initiator: takes one command, runs it on the bus with wait,
// retry and timeout handling, and returns a single registered response.
module bbbb_initiator
    import bbbb_pkg::*;
#(
    parameter int RETRY_MAX = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_cmd_valid,
    output logic        out_cmd_ready,
    input  logic        in_cmd_write,
    input  logic [31:0] in_cmd_addr,
    input  logic [31:0] in_cmd_wdata,
    output logic        out_rsp_valid,
    input  logic        in_rsp_accept,
    output logic [31:0] out_rsp_rdata,
    output logic [1:0]  out_rsp_err,
    output logic        out_bbbb_sel,
    output logic [31:0] out_bbbb_addr,
    output logic        out_bbbb_write,
    output logic [1:0]  out_bbbb_trans,
    output logic [31:0] out_bbbb_wdata,
    input  logic [31:0] in_bbbb_rdata,
    input  logic [1:0]  in_bbbb_resp,
    output logic        out_irq
);

    // Handshakes: a command transfers on a rising edge where in_cmd_valid
    // and out_cmd_ready are both high (ready is high only in IDLE); a
    // response transfers on an edge where out_rsp_valid and in_rsp_accept
    // are both high, and valid stays up with stable data until then.

    localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_BUSY = 2'(ST_BUSY);
    localparam logic [1:0] S_GAP  = 2'(ST_GAP);
    localparam logic [1:0] S_RESP = 2'(ST_RESP);

    logic [1:0]    state;
    logic [RW-1:0] retry_cnt;
    logic          wait_expired;
    logic          timer_clear;
    logic          timer_count;

    logic          done;
    logic [1:0]    done_err;
    logic [31:0]   done_rdata;
    logic          retry_go;

    assign timer_clear = (state != S_BUSY);
    assign timer_count = (state == S_BUSY) && (in_bbbb_resp == RESP_WAIT);

    bbbb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .count   (timer_count),
        .expired (wait_expired)
    );

    // Decode the response sampled this cycle into finish / reissue actions.
    always_comb begin
        done       = 1'b0;
        done_err   = ERR_OK;
        done_rdata = 32'h0;
        retry_go   = 1'b0;
        if (state == S_BUSY) begin
            case (in_bbbb_resp)
                RESP_OKAY: begin
                    done       = 1'b1;
                    done_rdata = out_bbbb_write ? 32'h0 : in_bbbb_rdata;
                end
                RESP_ERROR: begin
                    done     = 1'b1;
                    done_err = ERR_ERROR;
                end
                RESP_WAIT: begin
                    if (wait_expired) begin
                        done     = 1'b1;
                        done_err = ERR_TIMEOUT;
                    end
                end
                RESP_RETRY: begin
                    if (retry_cnt < RW'(RETRY_MAX)) begin
                        retry_go = 1'b1;
                    end else begin
                        done     = 1'b1;
                        done_err = ERR_RETRY_EXHAUSTED;
                    end
                end
                default: begin
                    done = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            out_cmd_ready  <= 1'b1;
            out_bbbb_sel   <= 1'b0;
            out_bbbb_trans <= TRANS_IDLE;
            out_bbbb_addr  <= 32'h0;
            out_bbbb_wdata <= 32'h0;
            out_bbbb_write <= 1'b0;
            out_rsp_valid  <= 1'b0;
            out_rsp_rdata  <= 32'h0;
            out_rsp_err    <= ERR_OK;
            out_irq        <= 1'b0;
            retry_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_cmd_valid) begin
                        out_bbbb_addr  <= in_cmd_addr;
                        out_bbbb_wdata <= in_cmd_wdata;
                        out_bbbb_write <= in_cmd_write;
                        out_bbbb_sel   <= 1'b1;
                        out_bbbb_trans <= TRANS_NONSEQ;
                        out_cmd_ready  <= 1'b0;
                        retry_cnt      <= '0;
                        state          <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (done) begin
                        out_bbbb_sel   <= 1'b0;
                        out_bbbb_trans <= TRANS_IDLE;
                        out_rsp_valid  <= 1'b1;
                        out_rsp_rdata  <= done_rdata;
                        out_rsp_err    <= done_err;
                        out_irq        <= is_fail(done_err);
                        state          <= S_RESP;
                    end else if (retry_go) begin
                        out_bbbb_sel   <= 1'b0;
                        out_bbbb_trans <= TRANS_IDLE;
                        retry_cnt      <= retry_cnt + 1'b1;
                        state          <= S_GAP;
                    end
                end
                S_GAP: begin
                    // Address, data and direction are untouched, so the
                    // reissue is the identical transfer.
                    out_bbbb_sel   <= 1'b1;
                    out_bbbb_trans <= TRANS_NONSEQ;
                    state          <= S_BUSY;
                end
                S_RESP: begin
                    if (in_rsp_accept) begin
                        out_rsp_valid <= 1'b0;
                        out_rsp_rdata <= 32'h0;
                        out_rsp_err   <= ERR_OK;
                        out_irq       <= 1'b0;
                        out_cmd_ready <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
